// File: rtl/rs_psel_gen.sv
// -----------------------------------------------------------------------------
// rs_psel_gen -- reservation-station issue selector
//
// Chooses up to REQS distinct ready entries from a WIDTH-bit request vector and
// drives one one-hot (or all-zero) grant vector per issue slot. The order of
// selection alternates between the two ends of the vector and moves inward:
// slot 0 gets the lowest set bit, slot 1 the highest, slot 2 the next lowest,
// slot 3 the next highest, and so on. No fairness state is kept. Set bits in
// the middle that do not fit into a slot are ignored.
//
// Ports:
//   clock    in   1           system clock; rising-edge active
//   reset    in   1           synchronous, active-high; clears gnt_bus
//   en       in   1           selection enable; gnt_bus is zero while low
//   req      in   WIDTH       request vector, bit k = entry k ready
//   gnt_bus  out  WIDTH*REQS  packed grants, slot i = gnt_bus[WIDTH*i +: WIDTH]
//
// Parameters:
//   REQS   number of grant slots (issue ports), >= 1
//   WIDTH  number of requesters (RS entries), >= 1
//
// Build option:
//   RS_PSEL_COMB_OUT_EN  when defined, the output register is removed and
//                        gnt_bus follows req/en/reset combinationally. The
//                        clock port stays on the module but is then unused.
// -----------------------------------------------------------------------------
module rs_psel_gen #(
    parameter int REQS  = 3,
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [WIDTH-1:0]        req,
    output logic [WIDTH*REQS-1:0]   gnt_bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ---- stage p0: combinational selection from req ----
    logic [WIDTH*REQS-1:0] gnt_p0;

    // Each slot takes its bit from whatever the earlier slots left behind, so
    // grants are disjoint by construction. This also keeps slots whose
    // inward pointers have crossed from granting a bit a second time.
    for (genvar s = 0; s < REQS; s++) begin : gen_slot
        logic [WIDTH-1:0] rem_in;
        logic [WIDTH-1:0] pick;
        logic [WIDTH-1:0] rem_out;

        if (s == 0) begin : gen_first
            assign rem_in = req;
        end else begin : gen_next
            assign rem_in = gen_slot[s-1].rem_out;
        end

        if ((s % 2) == 0) begin : gen_low
            // Scan downward: the last match written is the lowest set bit.
            always_comb begin
                pick = '0;
                for (int k = WIDTH - 1; k >= 0; k--) begin
                    if (rem_in[k]) pick = ONE << k;
                end
            end
        end else begin : gen_high
            // Scan upward: the last match written is the highest set bit.
            always_comb begin
                pick = '0;
                for (int k = 0; k < WIDTH; k++) begin
                    if (rem_in[k]) pick = ONE << k;
                end
            end
        end

        assign rem_out                  = rem_in & ~pick;
        assign gnt_p0[WIDTH*s +: WIDTH] = pick;
    end

`ifdef RS_PSEL_COMB_OUT_EN
    // ---- output: unregistered ----
    assign gnt_bus = (reset | ~en) ? '0 : gnt_p0;
`else
    // ---- stage p1: registered grants ----
    logic [WIDTH*REQS-1:0] gnt_p1;

    // A disabled cycle clears the grants instead of holding them, so a stale
    // grant is never issued twice.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_p1 <= '0;
        end else if (!en) begin
            gnt_p1 <= '0;
        end else begin
            gnt_p1 <= gnt_p0;
        end
    end

    assign gnt_bus = gnt_p1;
`endif

endmodule

// File: tb/tb_rs_psel_gen.sv
// -----------------------------------------------------------------------------
// tb_rs_psel_gen -- self-checking bench for rs_psel_gen (REQS=3, WIDTH=16),
// registered-output build.
// -----------------------------------------------------------------------------
module tb_rs_psel_gen;

    localparam int REQS  = 3;
    localparam int WIDTH = 16;

    logic                  clock;
    logic                  reset;
    logic                  en;
    logic [WIDTH-1:0]      req;
    logic [WIDTH*REQS-1:0] gnt_bus;

    int checks   = 0;
    int failures = 0;

    rs_psel_gen #(
        .REQS  (REQS),
        .WIDTH (WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .gnt_bus (gnt_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: list the set bit indices in ascending order, then hand them
    // out with two pointers, one from each end, alternating low/high.
    function automatic logic [WIDTH*REQS-1:0] model(input logic [WIDTH-1:0] r);
        int idx[WIDTH];
        int n;
        int lo;
        int hi;
        logic [WIDTH*REQS-1:0] res;
        n   = 0;
        res = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (r[k]) begin
                idx[n] = k;
                n++;
            end
        end
        lo = 0;
        hi = n - 1;
        for (int s = 0; s < REQS; s++) begin
            if (lo <= hi) begin
                if ((s % 2) == 0) begin
                    res[WIDTH*s + idx[lo]] = 1'b1;
                    lo++;
                end else begin
                    res[WIDTH*s + idx[hi]] = 1'b1;
                    hi--;
                end
            end
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        req   = 16'hffff;
        step();
        checks++;
        if (gnt_bus !== 48'h0) begin
            failures++;
            $display("FAIL reset_clear: got %h expected %h", gnt_bus, 48'h0);
        end
        reset = 1'b0;
        step();
        checks++;
        if (gnt_bus !== 48'h0002_8000_0001) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", gnt_bus, 48'h0002_8000_0001);
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] s0, s1, s2;
        req = 16'hffff;
        en  = 1'b1;
        step();
        s0 = gnt_bus[0 +: WIDTH];
        s1 = gnt_bus[WIDTH +: WIDTH];
        s2 = gnt_bus[2*WIDTH +: WIDTH];
        checks++;
        if (s0 !== 16'h0001) begin
            failures++;
            $display("FAIL full_slot0: got %h expected %h", s0, 16'h0001);
        end
        checks++;
        if (s1 !== 16'h8000) begin
            failures++;
            $display("FAIL full_slot1: got %h expected %h", s1, 16'h8000);
        end
        checks++;
        if (s2 !== 16'h0002) begin
            failures++;
            $display("FAIL full_slot2: got %h expected %h", s2, 16'h0002);
        end
    endtask

    task automatic test_sparse();
        logic [WIDTH-1:0]      vec [5];
        logic [WIDTH*REQS-1:0] exp [5];
        vec[0] = 16'h0001; exp[0] = 48'h0000_0000_0001;
        vec[1] = 16'h0101; exp[1] = 48'h0000_0100_0001;
        vec[2] = 16'h0007; exp[2] = 48'h0002_0004_0001;
        vec[3] = 16'h0000; exp[3] = 48'h0000_0000_0000;
        vec[4] = 16'h8421; exp[4] = 48'h0020_8000_0001;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = vec[i];
            step();
            checks++;
            if (gnt_bus !== exp[i]) begin
                failures++;
                $display("FAIL sparse req=%h: got %h expected %h", vec[i], gnt_bus, exp[i]);
            end
        end
    endtask

    task automatic test_enable();
        req = 16'hffff;
        en  = 1'b1;
        step();
        en = 1'b0;
        step();
        checks++;
        if (gnt_bus !== 48'h0) begin
            failures++;
            $display("FAIL enable_off: got %h expected %h", gnt_bus, 48'h0);
        end
        en = 1'b1;
        step();
        checks++;
        if (gnt_bus !== 48'h0002_8000_0001) begin
            failures++;
            $display("FAIL enable_resume: got %h expected %h", gnt_bus, 48'h0002_8000_0001);
        end
    endtask

    task automatic test_sweep();
        logic [WIDTH*REQS-1:0] exp;
        logic [WIDTH-1:0]      sl [REQS];
        logic [WIDTH-1:0]      acc;
        int                    nz;
        int                    want;
        bit                    ok;
        en = 1'b1;
        for (int v = 0; v < 65536; v++) begin
            req = v[WIDTH-1:0];
            step();
            exp = model(v[WIDTH-1:0]);
            checks++;
            if (gnt_bus !== exp) begin
                failures++;
                $display("FAIL sweep_model req=%h: got %h expected %h", v[WIDTH-1:0], gnt_bus, exp);
            end
            ok  = 1'b1;
            acc = '0;
            nz  = 0;
            for (int s = 0; s < REQS; s++) begin
                sl[s] = gnt_bus[WIDTH*s +: WIDTH];
                if (!$onehot0(sl[s])) ok = 1'b0;
                if ((acc & sl[s]) != '0) ok = 1'b0;
                acc = acc | sl[s];
                if (sl[s] != '0) nz++;
            end
            if ((acc & ~v[WIDTH-1:0]) != '0) ok = 1'b0;
            want = ($countones(v[WIDTH-1:0]) < REQS) ? $countones(v[WIDTH-1:0]) : REQS;
            if (nz != want) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL sweep_props req=%h: got %h, nonzero slots %0d expected %0d",
                         v[WIDTH-1:0], gnt_bus, nz, want);
            end
        end
    endtask

    task automatic test_priority();
        reset = 1'b0;
        en    = 1'b1;
        req   = 16'h00ff;
        step();
        checks++;
        if (gnt_bus !== 48'h0002_0080_0001) begin
            failures++;
            $display("FAIL priority_pre: got %h expected %h", gnt_bus, 48'h0002_0080_0001);
        end
        reset = 1'b1;
        step();
        checks++;
        if (gnt_bus !== 48'h0) begin
            failures++;
            $display("FAIL priority_reset_wins: got %h expected %h", gnt_bus, 48'h0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = '0;
        #1;
        test_reset();
        test_full();
        test_sparse();
        test_enable();
        test_priority();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
